tilelink_ul_reg_bridge: RTL and testbench
=========================================

Name: tilelink_ul_reg_bridge

Overview:
TileLink Uncached Lightweight slave endpoint that sits directly downstream of one crossbar slave port (sa_*/sd_*). It converts single-beat Get/PutFullData/PutPartialData requests into a simple req/ack register-bus transaction and returns AccessAck/AccessAckData on the D channel. It allows one outstanding transaction and denies malformed requests locally, without touching the register bus.

Parameters:
TL_AW, 32, address width
TL_DW, 5, log2 of data width in bits (32-bit bus by default)
TL_SZ, 4, width of a_size/d_size
TL_SRC, 3, source width, equal to crossbar TL_RS+$clog2(TLM)
TIMEOUT, 1024, register-bus cycles before the bridge gives up (used only with the optional feature)

Ports:
tilelink_clock_i  in  1  single clock, all state on posedge
tilelink_reset_i  in  1  synchronous, active-high reset
a_opcode  in  3  A opcode
a_param  in  3  A param, ignored
a_size  in  TL_SZ  log2 of bytes
a_source  in  TL_SRC  request ID
a_address  in  TL_AW  byte address
a_mask  in  2**TL_DW/8  byte lanes
a_data  in  2**TL_DW  write data
a_corrupt  in  1  write data corrupt
a_valid  in  1  A valid
a_ready  out  1  A ready
d_opcode  out  3  0=AccessAck, 1=AccessAckData
d_param  out  3  always 0
d_size  out  TL_SZ  echo of a_size
d_source  out  TL_SRC  echo of a_source
d_denied  out  1  request refused
d_data  out  2**TL_DW  read data
d_corrupt  out  1  read data invalid
d_valid  out  1  D valid
d_ready  in  1  D ready
reg_req_o  out  1  register access request, held until ack
reg_we_o  out  1  1=write
reg_addr_o  out  TL_AW  word-aligned address, low TL_DW-3 bits zero
reg_wdata_o  out  2**TL_DW  write data
reg_wmask_o  out  2**TL_DW/8  byte enables
reg_rdata_i  in  2**TL_DW  read data, valid with ack
reg_ack_i  in  1  completion, one cycle
reg_err_i  in  1  error qualifier, valid with ack

Behaviour:
- FSM states: IDLE, REQ, RESP. Reset forces IDLE. In reset, every output is 0, including a_ready. Reset takes effect at any point in a transaction and abandons it; no D beat is produced for the abandoned request.
- a_ready is 1 only in IDLE, and is a registered state decode with no combinational path from a_valid.
- A handshake (a_valid&a_ready) in IDLE registers opcode, size, source, address, mask, data and a legality flag.
- A request is illegal if any of these hold: opcode not in {0,1,4}; a_size>TL_DW-3; address not aligned to 2**a_size; a_corrupt=1 on a Put.
- Legal request: go to REQ. Illegal request: go to RESP with d_denied=1. reg_req_o stays 0.
- REQ: reg_req_o=1. Address, wdata and wmask are held stable. reg_we_o=1 for opcodes 0 and 1.
  - PutFullData drives wmask from a_mask unchanged; the mask is not checked.
  - Get drives wmask=0.
- reg_ack_i in REQ: next state RESP, reg_req_o drops in that same cycle. The bridge captures rdata and sets d_denied=reg_err_i.
- RESP: d_valid=1 with all D fields stable until d_ready. d_opcode is 1 for Get and 0 otherwise. d_size and d_source echo the request.
- d_corrupt=d_denied for Get, 0 for Puts. d_data is 0 on writes and on denied requests.
- d_valid&d_ready: go to IDLE. a_ready rises the following cycle, so back-to-back throughput is one request per 3 cycles minimum.
- Minimum latency: A handshake at cycle N → reg_req_o at N+1 → ack at N+1 → d_valid at N+2.
- reg_ack_i outside REQ is ignored.

Optional Feature:
TL_REG_BRIDGE_TIMEOUT_EN
- Defined: a counter (width $clog2(TIMEOUT+1)) clears on entry to REQ and increments every REQ cycle without ack.
  - When it reaches TIMEOUT, reg_req_o drops and the FSM goes to RESP with d_denied=1 (d_corrupt=1 for Get).
  - An ack arriving in the same cycle as the timeout wins.
- Undefined: no counter; REQ waits indefinitely for reg_req_o's ack.

Test Plan:
- Get addr 0x10, size 2, source 5; ack after 3 cycles with rdata 0xDEADBEEF, err 0 → reg_req_o high 3 cycles, reg_we_o=0; d_opcode=1, d_data=0xDEADBEEF, d_source=5, d_denied=0.
- PutPartialData addr 0x8, mask 4'b0110, data 0x11223344; immediate ack → reg_wmask_o=4'b0110, reg_addr_o=0x8; d_opcode=0, d_valid 2 cycles after the A handshake.
- Illegal cases: opcode 2, or size 3 at addr 0x4 → reg_req_o never asserts; d_denied=1, d_corrupt=1 only for Get-class, d_size echoed.
- d_ready held low 5 cycles during RESP → D fields stable; a_ready=0 throughout; a_ready=1 the cycle after d_ready.
- Get with ack plus reg_err_i=1 → d_denied=1, d_corrupt=1, d_data=0. Reset asserted while in REQ → outputs 0 next cycle, no D beat.
- TIMEOUT=8 with macro defined and no ack → d_denied=1 exactly 8 REQ cycles after entry, reg_req_o low on the same edge; without the macro, reg_req_o stays high after 100 cycles.

Source files
------------

// File: rtl/tilelink_ul_reg_bridge_if.sv
// rtl/tilelink_ul_reg_bridge_if.sv - TL-UL A/D channels plus req/ack register bus seen by the bridge
// master: crossbar and register-file side; slave: the bridge itself.
interface tilelink_ul_reg_bridge_if #(
    parameter int TL_AW  = 32,
    parameter int TL_DW  = 5,
    parameter int TL_SZ  = 4,
    parameter int TL_SRC = 3
);
    localparam int DW = 2**TL_DW;
    localparam int MW = DW / 8;

    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZ-1:0]  a_size;
    logic [TL_SRC-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [MW-1:0]     a_mask;
    logic [DW-1:0]     a_data;
    logic              a_corrupt;
    logic              a_valid;
    logic              a_ready;

    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZ-1:0]  d_size;
    logic [TL_SRC-1:0] d_source;
    logic              d_denied;
    logic [DW-1:0]     d_data;
    logic              d_corrupt;
    logic              d_valid;
    logic              d_ready;

    logic              reg_req_o;
    logic              reg_we_o;
    logic [TL_AW-1:0]  reg_addr_o;
    logic [DW-1:0]     reg_wdata_o;
    logic [MW-1:0]     reg_wmask_o;
    logic [DW-1:0]     reg_rdata_i;
    logic              reg_ack_i;
    logic              reg_err_i;

    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
        output d_ready,
        input  reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, reg_wmask_o,
        output reg_rdata_i, reg_ack_i, reg_err_i
    );

    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
        input  d_ready,
        output reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, reg_wmask_o,
        input  reg_rdata_i, reg_ack_i, reg_err_i
    );
endinterface

// File: rtl/tilelink_ul_reg_bridge.sv
// rtl/tilelink_ul_reg_bridge.sv - single-outstanding TL-UL slave to req/ack register bus bridge
// Optional register-bus timeout enabled by defining TL_REG_BRIDGE_TIMEOUT_EN.
module tilelink_ul_reg_bridge #(
    parameter int TL_AW   = 32,
    parameter int TL_DW   = 5,
    parameter int TL_SZ   = 4,
    parameter int TL_SRC  = 3,
    parameter int TIMEOUT = 1024
) (
    input logic                     tilelink_clock_i,
    input logic                     tilelink_reset_i,
    tilelink_ul_reg_bridge_if.slave bus
);
    localparam int DW = 2**TL_DW;
    localparam int MW = DW / 8;
    localparam int AL = TL_DW - 3;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;

    localparam logic [TL_AW-1:0] WORD_MASK = ~((TL_AW'(1) << AL) - TL_AW'(1));

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic              a_ready_q;
    logic [2:0]        op_q;
    logic [TL_SZ-1:0]  size_q;
    logic [TL_SRC-1:0] src_q;
    logic [TL_AW-1:0]  addr_q;
    logic [MW-1:0]     mask_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     rdata_q;
    logic              denied_q;

    logic              handshake;
    logic              illegal;
    logic              timeout;
    logic              in_req;
    logic              is_get;
    logic [TL_AW-1:0]  align_mask;

    assign handshake  = bus.a_valid && a_ready_q;
    assign in_req     = (state_q == REQ);
    assign is_get     = (op_q == OP_GET);
    assign align_mask = (TL_AW'(1) << bus.a_size) - TL_AW'(1);

    always_comb begin
        illegal = 1'b0;
        if (!(bus.a_opcode inside {OP_PUT_FULL, OP_PUT_PART, OP_GET}))
            illegal = 1'b1;
        if (bus.a_size > TL_SZ'(AL))
            illegal = 1'b1;
        if ((bus.a_address & align_mask) != '0)
            illegal = 1'b1;
        if (bus.a_corrupt && (bus.a_opcode != OP_GET))
            illegal = 1'b1;
    end

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    // Counter holds the number of completed ack-less REQ cycles; the last one trips it.
    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i || !in_req)
            cnt_q <= '0;
        else if (!bus.reg_ack_i)
            cnt_q <= cnt_q + CW'(1);
    end

    assign timeout = in_req && !bus.reg_ack_i && (cnt_q == CW'(TIMEOUT - 1));

    logic unused_cfg;
    assign unused_cfg = ^bus.a_param;
`else
    assign timeout = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{bus.a_param, 32'(TIMEOUT)};
`endif

    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (handshake) state_d = illegal ? RESP : REQ;
            REQ:  if (bus.reg_ack_i || timeout) state_d = RESP;
            RESP: if (bus.d_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i) begin
            a_ready_q <= 1'b0;
            op_q      <= '0;
            size_q    <= '0;
            src_q     <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            denied_q  <= 1'b0;
        end else begin
            a_ready_q <= (state_d == IDLE);
            if (handshake) begin
                op_q     <= bus.a_opcode;
                size_q   <= bus.a_size;
                src_q    <= bus.a_source;
                addr_q   <= bus.a_address;
                mask_q   <= bus.a_mask;
                wdata_q  <= bus.a_data;
                rdata_q  <= '0;
                denied_q <= illegal;
            end else if (in_req && bus.reg_ack_i) begin
                // Read data only survives a clean Get; writes and errors return zero.
                rdata_q  <= (is_get && !bus.reg_err_i) ? bus.reg_rdata_i : '0;
                denied_q <= bus.reg_err_i;
            end else if (timeout) begin
                denied_q <= 1'b1;
            end
        end
    end

    assign bus.a_ready     = a_ready_q;

    assign bus.d_valid     = (state_q == RESP);
    assign bus.d_opcode    = {2'b00, is_get};
    assign bus.d_param     = 3'd0;
    assign bus.d_size      = size_q;
    assign bus.d_source    = src_q;
    assign bus.d_denied    = denied_q;
    assign bus.d_data      = rdata_q;
    assign bus.d_corrupt   = is_get && denied_q;

    assign bus.reg_req_o   = in_req;
    assign bus.reg_we_o    = in_req && !is_get;
    assign bus.reg_addr_o  = in_req ? (addr_q & WORD_MASK) : '0;
    assign bus.reg_wdata_o = in_req ? wdata_q : '0;
    assign bus.reg_wmask_o = (in_req && !is_get) ? mask_q : '0;
endmodule

// File: tb/tb_tilelink_ul_reg_bridge.sv
// tb/tb_tilelink_ul_reg_bridge.sv - directed self-checking bench for tilelink_ul_reg_bridge
module tb_tilelink_ul_reg_bridge;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    tilelink_ul_reg_bridge_if #(.TL_AW(32), .TL_DW(5), .TL_SZ(4), .TL_SRC(3)) bus ();

    tilelink_ul_reg_bridge #(
        .TL_AW(32), .TL_DW(5), .TL_SZ(4), .TL_SRC(3), .TIMEOUT(8)
    ) dut (
        .tilelink_clock_i(clk),
        .tilelink_reset_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [2:0] op, input logic [3:0] size, input logic [2:0] src,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                          input logic corrupt);
        bus.a_opcode  = op;
        bus.a_size    = size;
        bus.a_source  = src;
        bus.a_address = addr;
        bus.a_mask    = mask;
        bus.a_data    = data;
        bus.a_corrupt = corrupt;
        bus.a_valid   = 1'b1;
        tick();
        bus.a_valid   = 1'b0;
        bus.a_corrupt = 1'b0;
    endtask

    task automatic finish_d();
        bus.d_ready = 1'b1;
        tick();
        bus.d_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0; bus.a_source = '0;
        bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0; bus.a_corrupt = 1'b0;
        bus.a_valid = 1'b0; bus.d_ready = 1'b0;
        bus.reg_rdata_i = '0; bus.reg_ack_i = 1'b0; bus.reg_err_i = 1'b0;

        tick();
        tick();
        chk("rst_a_ready", bus.a_ready, 0);
        chk("rst_d_valid", bus.d_valid, 0);
        chk("rst_reg_req", bus.reg_req_o, 0);
        chk("rst_d_data", bus.d_data, 0);
        rst = 1'b0;
        tick();
        chk("idle_a_ready", bus.a_ready, 1);

        // Get 0x10, ack in third REQ cycle
        send_a(3'd4, 4'd2, 3'd5, 32'h10, 4'hF, 32'h0, 1'b0);
        chk("get_req_c1", bus.reg_req_o, 1);
        chk("get_we", bus.reg_we_o, 0);
        chk("get_addr", bus.reg_addr_o, 32'h10);
        chk("get_wmask", bus.reg_wmask_o, 0);
        chk("get_a_ready", bus.a_ready, 0);
        tick();
        chk("get_req_c2", bus.reg_req_o, 1);
        tick();
        chk("get_req_c3", bus.reg_req_o, 1);
        bus.reg_ack_i = 1'b1;
        bus.reg_rdata_i = 32'hDEADBEEF;
        tick();
        bus.reg_ack_i = 1'b0;
        chk("get_req_drop", bus.reg_req_o, 0);
        chk("get_d_valid", bus.d_valid, 1);
        chk("get_d_opcode", bus.d_opcode, 1);
        chk("get_d_data", bus.d_data, 32'hDEADBEEF);
        chk("get_d_source", bus.d_source, 5);
        chk("get_d_size", bus.d_size, 2);
        chk("get_d_denied", bus.d_denied, 0);
        chk("get_d_corrupt", bus.d_corrupt, 0);
        finish_d();
        chk("get_done_valid", bus.d_valid, 0);
        chk("get_done_a_ready", bus.a_ready, 1);

        // PutPartialData with immediate ack, then D back-pressure
        send_a(3'd1, 4'd2, 3'd2, 32'h8, 4'b0110, 32'h11223344, 1'b0);
        chk("pp_req", bus.reg_req_o, 1);
        chk("pp_we", bus.reg_we_o, 1);
        chk("pp_wmask", bus.reg_wmask_o, 4'b0110);
        chk("pp_addr", bus.reg_addr_o, 32'h8);
        chk("pp_wdata", bus.reg_wdata_o, 32'h11223344);
        bus.reg_ack_i = 1'b1;
        bus.reg_rdata_i = 32'hCAFEF00D;
        tick();
        bus.reg_ack_i = 1'b0;
        chk("pp_d_valid", bus.d_valid, 1);
        chk("pp_d_opcode", bus.d_opcode, 0);
        chk("pp_d_data", bus.d_data, 0);
        chk("pp_d_corrupt", bus.d_corrupt, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pp_hold_valid", bus.d_valid, 1);
            chk("pp_hold_src", bus.d_source, 2);
            chk("pp_hold_opcode", bus.d_opcode, 0);
            chk("pp_hold_denied", bus.d_denied, 0);
            chk("pp_hold_a_ready", bus.a_ready, 0);
        end
        finish_d();
        chk("pp_a_ready_after", bus.a_ready, 1);

        // PutFullData passes the mask through unchecked
        send_a(3'd0, 4'd2, 3'd7, 32'h24, 4'b1001, 32'hA5A5A5A5, 1'b0);
        chk("pf_wmask", bus.reg_wmask_o, 4'b1001);
        chk("pf_we", bus.reg_we_o, 1);
        bus.reg_ack_i = 1'b1;
        tick();
        bus.reg_ack_i = 1'b0;
        chk("pf_d_opcode", bus.d_opcode, 0);
        finish_d();

        // Illegal opcode 2
        send_a(3'd2, 4'd2, 3'd3, 32'h0, 4'hF, 32'h0, 1'b0);
        chk("op2_req", bus.reg_req_o, 0);
        chk("op2_d_valid", bus.d_valid, 1);
        chk("op2_denied", bus.d_denied, 1);
        chk("op2_corrupt", bus.d_corrupt, 0);
        chk("op2_d_size", bus.d_size, 2);
        finish_d();

        // Illegal Get size 3 at 0x4
        send_a(3'd4, 4'd3, 3'd1, 32'h4, 4'hF, 32'h0, 1'b0);
        chk("sz3_req", bus.reg_req_o, 0);
        chk("sz3_d_valid", bus.d_valid, 1);
        chk("sz3_denied", bus.d_denied, 1);
        chk("sz3_corrupt", bus.d_corrupt, 1);
        chk("sz3_d_size", bus.d_size, 3);
        chk("sz3_d_data", bus.d_data, 0);
        finish_d();

        // Misaligned Get and corrupt Put
        send_a(3'd4, 4'd1, 3'd4, 32'h3, 4'hF, 32'h0, 1'b0);
        chk("mis_req", bus.reg_req_o, 0);
        chk("mis_denied", bus.d_denied, 1);
        finish_d();
        send_a(3'd0, 4'd2, 3'd6, 32'h0, 4'hF, 32'h1, 1'b1);
        chk("cor_req", bus.reg_req_o, 0);
        chk("cor_denied", bus.d_denied, 1);
        chk("cor_corrupt", bus.d_corrupt, 0);
        finish_d();

        // Legal byte Get at odd address
        send_a(3'd4, 4'd0, 3'd0, 32'h13, 4'h8, 32'h0, 1'b0);
        chk("byte_req", bus.reg_req_o, 1);
        chk("byte_addr", bus.reg_addr_o, 32'h10);
        bus.reg_ack_i = 1'b1;
        tick();
        bus.reg_ack_i = 1'b0;
        finish_d();

        // Get with register error
        send_a(3'd4, 4'd2, 3'd5, 32'h20, 4'hF, 32'h0, 1'b0);
        bus.reg_ack_i = 1'b1;
        bus.reg_err_i = 1'b1;
        bus.reg_rdata_i = 32'h55AA55AA;
        tick();
        bus.reg_ack_i = 1'b0;
        bus.reg_err_i = 1'b0;
        chk("err_denied", bus.d_denied, 1);
        chk("err_corrupt", bus.d_corrupt, 1);
        chk("err_data", bus.d_data, 0);
        finish_d();

        // Stray ack in IDLE is ignored
        bus.reg_ack_i = 1'b1;
        tick();
        bus.reg_ack_i = 1'b0;
        chk("stray_d_valid", bus.d_valid, 0);
        chk("stray_a_ready", bus.a_ready, 1);

        // Reset while in REQ abandons the request
        send_a(3'd4, 4'd2, 3'd1, 32'h30, 4'hF, 32'h0, 1'b0);
        chk("rq_req", bus.reg_req_o, 1);
        rst = 1'b1;
        tick();
        chk("rq_req_off", bus.reg_req_o, 0);
        chk("rq_d_valid", bus.d_valid, 0);
        chk("rq_a_ready", bus.a_ready, 0);
        chk("rq_addr", bus.reg_addr_o, 0);
        rst = 1'b0;
        bus.reg_ack_i = 1'b1;
        tick();
        bus.reg_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rq_no_dbeat", bus.d_valid, 0);
            tick();
        end
        chk("rq_a_ready_back", bus.a_ready, 1);

        // Get with no ack
        send_a(3'd4, 4'd2, 3'd3, 32'h40, 4'hF, 32'h0, 1'b0);
        chk("to_req_c1", bus.reg_req_o, 1);
`ifdef TL_REG_BRIDGE_TIMEOUT_EN
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("to_req_held", bus.reg_req_o, 1);
            chk("to_no_d", bus.d_valid, 0);
        end
        tick();
        chk("to_req_drop", bus.reg_req_o, 0);
        chk("to_d_valid", bus.d_valid, 1);
        chk("to_denied", bus.d_denied, 1);
        chk("to_corrupt", bus.d_corrupt, 1);
        finish_d();
        chk("to_a_ready", bus.a_ready, 1);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("noto_req_held", bus.reg_req_o, 1);
        end
        chk("noto_d_valid", bus.d_valid, 0);
        bus.reg_ack_i = 1'b1;
        bus.reg_rdata_i = 32'h0BADF00D;
        tick();
        bus.reg_ack_i = 1'b0;
        chk("noto_late_data", bus.d_data, 32'h0BADF00D);
        chk("noto_late_denied", bus.d_denied, 0);
        finish_d();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
